os256_sample_feeder: RTL and testbench

//   Upstream stage of the x256 oversampling DAC path. Buffers stereo PCM words from a

---
 rtl/os256_pkg.sv | 16 +
 rtl/os256_sync_fifo.sv | 66 ++++++
 rtl/os256_sample_feeder.sv | 95 +++++++++
 tb/tb_os256_sample_feeder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/os256_pkg.sv
// Shared constants and the stereo word layout for the x256 oversampling DAC path.
package os256_pkg;

    localparam int OS256_DIVIDE   = 256;
    localparam int OS256_SAMPLE_W = 16;
    localparam int OS256_STEREO_W = 2 * OS256_SAMPLE_W;

    localparam int UNDERRUN_HOLD     = 0;
    localparam int UNDERRUN_ZERO_OUT = 1;

    typedef struct packed {
        logic [OS256_SAMPLE_W-1:0] left;
        logic [OS256_SAMPLE_W-1:0] right;
    } stereo_t;

endpackage

// File: rtl/os256_sync_fifo.sv
// Small synchronous FIFO built from a register array with a separate level counter.
module os256_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int AW    = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      level_o
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    // Head word comes straight out of the register array: no path from any input.
    assign rd_data_o = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o  & ~flush_i;
    assign do_pop  = pop_i  & ~empty_o & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            level_d = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/os256_sample_feeder.sv
// Buffers stereo PCM words and pops one per sample period, raising fs_timing
// for the downstream os256_dac pair on the last phase of every period.
module os256_sample_feeder
    import os256_pkg::*;
#(
    parameter int DIVIDE        = OS256_DIVIDE,
    parameter int FIFO_AW       = 4,
    parameter int UNDERRUN_ZERO = UNDERRUN_HOLD
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [OS256_STEREO_W-1:0] in_data,
    output logic                      fs_timing,
    output logic [OS256_SAMPLE_W-1:0] sample_l,
    output logic [OS256_SAMPLE_W-1:0] sample_r,
    output logic [FIFO_AW:0]          fifo_level,
    output logic                      underrun,
    output logic [7:0]                underrun_count
);

    localparam int PW = $clog2(DIVIDE);

    logic [PW-1:0] phase_q, phase_d;
    stereo_t       sample_q, sample_d;
    logic          underrun_q, underrun_d;
    logic [7:0]    ur_cnt_q, ur_cnt_d;

    logic                      pop_edge;
    logic                      fifo_full, fifo_empty;
    logic [OS256_STEREO_W-1:0] fifo_rd;

    os256_sync_fifo #(
        .WIDTH (OS256_STEREO_W),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk_i     (clk),
        .reset_i   (reset),
        .push_i    (in_valid & ~fifo_full),
        .pop_i     (pop_edge),
        .flush_i   (flush),
        .wr_data_i (in_data),
        .rd_data_o (fifo_rd),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .level_o   (fifo_level)
    );

    assign pop_edge = enable && (phase_q == PW'(DIVIDE - 2));

    always_comb begin
        phase_d = phase_q + PW'(1);
        if (!enable || phase_q == PW'(DIVIDE - 1)) phase_d = '0;
    end

    // A flushed pop still counts as an underrun when the FIFO was empty,
    // but never consumes a word or disturbs the held sample pair.
    always_comb begin
        sample_d   = sample_q;
        underrun_d = pop_edge & fifo_empty;
        ur_cnt_d   = ur_cnt_q;
        if (pop_edge && !fifo_empty && !flush) sample_d = stereo_t'(fifo_rd);
        if (underrun_d) begin
            if (UNDERRUN_ZERO != UNDERRUN_HOLD) sample_d = '0;
            if (ur_cnt_q != 8'hFF) ur_cnt_d = ur_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q    <= '0;
            sample_q   <= '0;
            underrun_q <= 1'b0;
            ur_cnt_q   <= '0;
        end else begin
            phase_q    <= phase_d;
            sample_q   <= sample_d;
            underrun_q <= underrun_d;
            ur_cnt_q   <= ur_cnt_d;
        end
    end

    // Phase only reaches DIVIDE-1 through a cycle with enable high, so the
    // strobe decodes from the phase register alone.
    assign fs_timing      = (phase_q == PW'(DIVIDE - 1));
    assign in_ready       = ~fifo_full;
    assign sample_l       = sample_q.left;
    assign sample_r       = sample_q.right;
    assign underrun       = underrun_q;
    assign underrun_count = ur_cnt_q;

endmodule

// File: tb/tb_os256_sample_feeder.sv
// Scoreboard bench for os256_sample_feeder: pushed words queue up and are
// matched against the sample pair on every fs_timing strobe.
module tb_os256_sample_feeder;
    import os256_pkg::*;

    localparam int DIV = 256;
    localparam int AW  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1, enable = 1'b0, flush = 1'b0, in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready, fs_timing, underrun;
    logic [15:0] sample_l, sample_r;
    logic [AW:0] fifo_level;
    logic [7:0]  underrun_count;

    os256_sample_feeder #(.DIVIDE(DIV), .FIFO_AW(AW), .UNDERRUN_ZERO(0)) dut (
        .clk(clk), .reset(reset), .enable(enable), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .fs_timing(fs_timing), .sample_l(sample_l), .sample_r(sample_r),
        .fifo_level(fifo_level), .underrun(underrun), .underrun_count(underrun_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] d;
        int          c;
    } sb_t;
    sb_t         exp_q[$];
    int          cyc = 0;
    logic        rst_ev = 1'b0;
    logic [31:0] last_d = '0;
    int          ur_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Record accepted words with the index of the edge that took them.
    always @(posedge clk) begin
        rst_ev <= reset;
        if (reset) exp_q.delete();
        else if (flush) exp_q.delete();
        else if (in_valid && in_ready) exp_q.push_back('{in_data, cyc});
        cyc <= cyc + 1;
    end

    // A word taken on the pop edge itself is not available to that pop.
    always @(negedge clk) begin
        if (rst_ev) begin
            last_d <= '0;
            ur_cnt <= 0;
        end else if (fs_timing) begin
            if (exp_q.size() > 0 && exp_q[0].c < cyc - 1) begin
                chk("samp", {sample_l, sample_r}, exp_q[0].d);
                chk("ur_lo", {31'b0, underrun}, 32'd0);
                last_d <= exp_q[0].d;
                void'(exp_q.pop_front());
            end else begin
                chk("hold", {sample_l, sample_r}, last_d);
                chk("ur_hi", {31'b0, underrun}, 32'd1);
                chk("ur_cnt", {24'b0, underrun_count}, (ur_cnt < 255) ? ur_cnt + 1 : 255);
                if (ur_cnt < 255) ur_cnt <= ur_cnt + 1;
            end
        end else begin
            chk("ur_idle", {31'b0, underrun}, 32'd0);
        end
    end

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1; enable = 1'b0; flush = 1'b0; in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic chk_reset_vals;
        chk("rst_rdy", {31'b0, in_ready}, 32'd1);
        chk("rst_fs",  {31'b0, fs_timing}, 32'd0);
        chk("rst_smp", {sample_l, sample_r}, 32'd0);
        chk("rst_lvl", {27'b0, fifo_level}, 32'd0);
        chk("rst_ur",  {31'b0, underrun}, 32'd0);
        chk("rst_cnt", {24'b0, underrun_count}, 32'd0);
    endtask

    task automatic push_word(input logic [31:0] d);
        int n = 0;
        in_valid = 1'b1; in_data = d;
        while (!in_ready && n < 4 * DIV) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("push_to", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_fs;
        int n = 0;
        @(negedge clk);
        while (!fs_timing && n < 2 * DIV) begin
            @(negedge clk);
            n++;
        end
        if (!fs_timing) chk("fs_to", 32'd0, 32'd1);
    endtask

    task automatic measure_fs(output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!fs_timing && n < 2 * DIV);
    endtask

    // Called from the negedge of an fs cycle; drives one word onto the next pop edge.
    task automatic push_at_pop(input logic [31:0] d);
        repeat (DIV - 1) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b1; in_data = d;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        int n;

        // basic pop and first-strobe latency
        do_reset;
        chk_reset_vals;
        push_word(32'h7FFF_8000);
        enable = 1'b1;
        measure_fs(n);
        chk("fs_lat", n, DIV - 1);
        chk("t1_lvl", {27'b0, fifo_level}, 32'd0);
        enable = 1'b0;

        // fill to full, stall the 17th, then drain in order
        do_reset;
        for (int i = 0; i < 16; i++) push_word(32'hA000_0000 + i * 32'h0001_0003);
        chk("full_lvl", {27'b0, fifo_level}, 32'd16);
        chk("full_rdy", {31'b0, in_ready}, 32'd0);
        in_valid = 1'b1; in_data = 32'hC0DE_0017;
        repeat (3) @(negedge clk);
        chk("stall_lvl", {27'b0, fifo_level}, 32'd16);
        enable = 1'b1;
        n = 0;
        while (!in_ready && n < 2 * DIV) begin
            @(negedge clk);
            n++;
        end
        chk("stall_rel", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (16) wait_fs;
        enable = 1'b0;
        @(negedge clk);
        chk("sb_drain", exp_q.size(), 32'd0);

        // push coinciding with the pop edge, level 1 and level 0
        do_reset;
        push_word(32'h1111_AAAA);
        push_word(32'h2222_BBBB);
        enable = 1'b1;
        wait_fs;
        chk("lvl_p1", {27'b0, fifo_level}, 32'd1);
        push_at_pop(32'h3333_CCCC);
        chk("lvl_keep", {27'b0, fifo_level}, 32'd1);
        repeat (DIV) @(posedge clk);
        @(negedge clk);
        chk("lvl_empty", {27'b0, fifo_level}, 32'd0);
        push_at_pop(32'h4444_DDDD);
        chk("lvl_ur_push", {27'b0, fifo_level}, 32'd1);
        chk("ur_same", {31'b0, underrun}, 32'd1);
        wait_fs;
        enable = 1'b0;

        // flush mid-period
        do_reset;
        for (int i = 0; i < 5; i++) push_word(32'h5000_0000 + i);
        chk("fl_pre", {27'b0, fifo_level}, 32'd5);
        enable = 1'b1;
        repeat (100) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        chk("fl_lvl", {27'b0, fifo_level}, 32'd0);
        chk("fl_rdy", {31'b0, in_ready}, 32'd1);
        wait_fs;
        enable = 1'b0;

        // enable drop, re-enable, reset mid-period
        do_reset;
        enable = 1'b1;
        repeat (100) @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("fs_off", {31'b0, fs_timing}, 32'd0);
        end
        enable = 1'b1;
        measure_fs(n);
        chk("fs_relat", n, DIV - 1);
        repeat (201) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_reset_vals;
        reset = 1'b0; enable = 1'b0;

        // sustained underrun: hold last pair, counter saturates
        do_reset;
        push_word(32'h1234_5678);
        enable = 1'b1;
        repeat (257) wait_fs;
        chk("ur_sat", {24'b0, underrun_count}, 32'h0000_00FF);
        enable = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
